// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared types and default widths for the CAM command sequencer.
//   cam_op_e    : command opcodes carried on cmd_op
//   cam_state_e : sequencer FSM states
//   DW_DEF/AW_DEF/CW_DEF : default data, address and counter widths
// -----------------------------------------------------------------------------
package cam_pkg;

    localparam int DW_DEF = 4;
    localparam int AW_DEF = 3;
    localparam int CW_DEF = 8;

    typedef enum logic [1:0] {
        OP_LOOKUP  = 2'b00,
        OP_REPLACE = 2'b01,
        OP_INIT    = 2'b10,
        OP_RSVD    = 2'b11
    } cam_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_LOOK,
        ST_WRITE,
        ST_RESP
    } cam_state_e;

endpackage

// File: rtl/cam_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// cam_cmd_ctrl_if
// Command and response handshakes of the CAM sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_key/cmd_data : command channel
//   rsp_valid/rsp_ready/rsp_hit/rsp_multi/rsp_min_addr/rsp_max_addr : response
//   master : command issuer / response consumer
//   slave  : the sequencer
// -----------------------------------------------------------------------------
interface cam_cmd_ctrl_if #(
    parameter int DW = cam_pkg::DW_DEF,
    parameter int AW = cam_pkg::AW_DEF
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_key;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_hit;
    logic          rsp_multi;
    logic [AW-1:0] rsp_min_addr;
    logic [AW-1:0] rsp_max_addr;

    modport master (
        output cmd_valid, cmd_op, cmd_key, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_hit, rsp_multi, rsp_min_addr, rsp_max_addr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_key, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_hit, rsp_multi, rsp_min_addr, rsp_max_addr
    );
endinterface

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones.
//   clk   : clock
//   clear : synchronous clear, dominates inc
//   inc   : count up by one unless already saturated
//   count : current value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cam_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// cam_cmd_ctrl
// Sequencer in front of the CAM register file: takes LOOKUP/REPLACE/INIT
// commands, drives the CAM control inputs, returns one response per command
// and keeps saturating hit/miss counters.
//   clk, reset       : clock, synchronous active-high reset
//   bus (slave)      : command / response handshakes
//   cam_init         : CAM init strobe
//   cam_d_lookup     : CAM search key
//   cam_setd/newd    : CAM write strobe and replacement value
//   cam_valid/min/max: CAM match result for cam_d_lookup
//   hit_cnt/miss_cnt : debug counters
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | cmd_ready=1, waiting for a command
// ST_INIT  | one-cycle cam_init pulse
// ST_LOOK  | key on cam_d_lookup, CAM result captured at end of cycle
// ST_WRITE | cam_setd pulse, matching entries replaced with cam_newd
// ST_RESP  | rsp_valid=1 until consumer takes it
// -----------------------------------------------------------------------------
module cam_cmd_ctrl
    import cam_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    cam_cmd_ctrl_if.slave bus,
    output logic          cam_init,
    output logic [DW-1:0] cam_d_lookup,
    output logic          cam_setd,
    output logic [DW-1:0] cam_newd,
    input  logic          cam_valid,
    input  logic [AW-1:0] cam_min_addr,
    input  logic [AW-1:0] cam_max_addr,
    output logic [CW-1:0] hit_cnt,
    output logic [CW-1:0] miss_cnt
);

    cam_state_e    state_q, state_d;
    cam_op_e       op_q;
    logic [DW-1:0] key_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] lookup_q;
    logic          hit_q;
    logic          multi_q;
    logic [AW-1:0] min_q;
    logic [AW-1:0] max_q;
    logic          accept;
    logic          hit_inc;
    logic          miss_inc;

    assign accept = bus.cmd_valid && (state_q == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_LOOKUP;
            key_q    <= '0;
            data_q   <= '0;
            lookup_q <= '0;
            hit_q    <= 1'b0;
            multi_q  <= 1'b0;
            min_q    <= '0;
            max_q    <= '0;
        end else begin
            if (accept) begin
                // INIT and reserved commands respond with these cleared fields
                op_q    <= cam_op_e'(bus.cmd_op);
                key_q   <= bus.cmd_key;
                data_q  <= bus.cmd_data;
                hit_q   <= 1'b0;
                multi_q <= 1'b0;
                min_q   <= '0;
                max_q   <= '0;
            end
            if (state_q == ST_LOOK) begin
                lookup_q <= key_q;
                hit_q    <= cam_valid;
                multi_q  <= cam_valid && (cam_min_addr != cam_max_addr);
                min_q    <= cam_valid ? cam_min_addr : '0;
                max_q    <= cam_valid ? cam_max_addr : '0;
            end
        end
    end

    // CAM strobes are gated by reset so a reset landing mid-command
    // cannot commit a write or init on that same edge.
    always_comb begin
        state_d       = state_q;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        cam_init      = 1'b0;
        cam_setd      = 1'b0;
        cam_d_lookup  = lookup_q;
        cam_newd      = '0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    case (cam_op_e'(bus.cmd_op))
                        OP_INIT: state_d = ST_INIT;
                        OP_RSVD: state_d = ST_RESP;
                        default: state_d = ST_LOOK;
                    endcase
                end
            end
            ST_INIT: begin
                cam_init = !reset;
                state_d  = ST_RESP;
            end
            ST_LOOK: begin
                cam_d_lookup = key_q;
                hit_inc      = cam_valid;
                miss_inc     = !cam_valid;
                state_d      = ((op_q == OP_REPLACE) && cam_valid) ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                cam_d_lookup = key_q;
                cam_setd     = !reset;
                cam_newd     = data_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.rsp_hit      = hit_q;
    assign bus.rsp_multi    = multi_q;
    assign bus.rsp_min_addr = min_q;
    assign bus.rsp_max_addr = max_q;

    sat_counter #(.CW(CW)) u_hit_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (hit_inc),
        .count (hit_cnt)
    );

    sat_counter #(.CW(CW)) u_miss_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (miss_inc),
        .count (miss_cnt)
    );

endmodule

// File: doc/cam_cmd_ctrl.md
Name: cam_cmd_ctrl

Overview:
- Command sequencer that sits directly upstream of the 8x4 CAM register file.
- Accepts LOOKUP / REPLACE / INIT commands over a valid/ready handshake and drives the CAM's init, lookup-key, setD and newD inputs.
- Samples the CAM's valid/minAddr/maxAddr outputs and returns one response per command over a valid/ready handshake.
- Keeps saturating hit/miss counters for debug.

Parameters:
- DW, 4, CAM data/key width.
- AW, 3, CAM address width (2**AW entries).
- CW, 8, hit/miss counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00=LOOKUP, 01=REPLACE, 10=INIT, 11=reserved.
- cmd_key  in  DW  value to search for.
- cmd_data  in  DW  replacement value (REPLACE only).
- cam_init  out  1  to CAM init.
- cam_d_lookup  out  DW  to CAM D_Lookup.
- cam_setd  out  1  to CAM setD.
- cam_newd  out  DW  to CAM newD.
- cam_valid  in  1  from CAM valid (combinational match on current key).
- cam_min_addr  in  AW  from CAM minAddr.
- cam_max_addr  in  AW  from CAM maxAddr.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_hit  out  1  key matched at least one entry.
- rsp_multi  out  1  hit and min_addr != max_addr.
- rsp_min_addr  out  AW  lowest matching address (0 on miss).
- rsp_max_addr  out  AW  highest matching address (0 on miss).
- hit_cnt  out  CW  saturating count of hits.
- miss_cnt  out  CW  saturating count of misses.

Behaviour:
- States are IDLE, INIT, LOOK, WRITE, RESP. Reset forces IDLE from any state, including mid-command; the in-flight command is dropped and no CAM write is issued.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_* fields=0, cam_init=0, cam_setd=0, cam_d_lookup=0, cam_newd=0, hit_cnt=0, miss_cnt=0.
- cmd_ready=1 only in IDLE. The handshake completes on a rising edge with cmd_valid&cmd_ready; op, key and data are latched at that edge.
- IDLE -> INIT for op 10, -> LOOK for op 00/01. Op 11 goes straight to RESP with hit=0, and the counters are unchanged.
- INIT lasts 1 cycle: cam_init=1. Then -> RESP with hit=0, multi=0, addrs=0; the counters are unchanged.
- LOOK lasts 1 cycle: cam_d_lookup=latched key, cam_setd=0. At the end of the cycle, cam_valid/min/max are registered into the rsp fields and hit_cnt or miss_cnt increments by 1, saturating at 2**CW-1.
- LOOK exit: REPLACE with hit -> WRITE; otherwise -> RESP.
- WRITE lasts 1 cycle: cam_d_lookup=key, cam_setd=1, cam_newd=latched data. The CAM commits on that edge. The rsp fields keep the LOOK results (pre-write). Then -> RESP.
- RESP: rsp_valid=1 and the fields are held stable until rsp_valid&rsp_ready, then -> IDLE.
- Latency, accept edge to rsp_valid: LOOKUP and INIT take 2 cycles; REPLACE-hit takes 3; REPLACE-miss takes 2.
- Back-to-back commands: a new command is accepted in the IDLE cycle after the response handshake. Throughput is at most 1 command per 3 cycles.
- Default drive: outside LOOK/WRITE, cam_d_lookup holds its last key, and cam_setd=0, cam_init=0.
- A miss forces rsp_min_addr=rsp_max_addr=0 regardless of the CAM outputs.

Decomposition:
- Package cam_pkg holds the op enum (OP_LOOKUP, OP_REPLACE, OP_INIT, OP_RSVD), the state enum, and the DW/AW defaults.
- Sub-module sat_counter (width CW, inc, clear) is instantiated twice for hit_cnt and miss_cnt. Everything else is flat.

Test Plan:
- Bench CAM model: init loads entry i with {1'b1, i[2:0]}, so 4'b1011 is at address 3.
- INIT, then LOOKUP key 4'b1011 -> after 2 cycles rsp_valid=1, hit=1, multi=0, min=max=3; hit_cnt=1.
- REPLACE key 4'b1011, data 4'b1110 -> cam_setd pulses exactly 1 cycle with newd=4'b1110; then rsp hit=1, min=max=3. A following LOOKUP 4'b1011 returns hit=0 with addrs=0, and a LOOKUP 4'b1110 returns hit=1, min=3, max=6, multi=1.
- REPLACE key 4'b1110, data 4'b1010 -> cam_setd pulses once. A following LOOKUP 4'b1010 returns hit=1, min=2, max=6, multi=1.
- REPLACE with key 4'b0001 (absent) -> cam_setd never asserts, rsp hit=0 at 2 cycles, miss_cnt increments.
- Hold rsp_ready=0 for 5 cycles -> rsp fields are stable, cmd_ready=0, a pending cmd_valid is not accepted, and the counters do not move.
- Assert reset during WRITE -> no CAM write occurs; the next cycle has cmd_ready=1, rsp_valid=0, and both counters at 0.
- Issue 300 LOOKUP hits -> hit_cnt saturates at 255.
